// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared character constants and sequencer state encoding
//
// Purpose: constants used by the ALU string front-end and its FIFO.
// Ports:   none (package).

package alu_pkg;

    localparam logic [7:0] CH_STAR = 8'd42;
    localparam logic [7:0] CH_PLUS = 8'd43;
    localparam logic [7:0] CH_0    = 8'd48;
    localparam logic [7:0] CH_9    = 8'd57;
    localparam logic [7:0] CH_EQ   = 8'd61;

    localparam logic [1:0] S_CLEAR  = 2'd0;
    localparam logic [1:0] S_FEED   = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_REPORT = 2'd3;

    typedef enum logic [1:0] {
        ST_CLEAR  = S_CLEAR,
        ST_FEED   = S_FEED,
        ST_SAMPLE = S_SAMPLE,
        ST_REPORT = S_REPORT
    } state_t;

endpackage

// File: rtl/string_seq_ctrl_if.sv
// rtl/string_seq_ctrl_if.sv - character stream handshake into the sequencer
//
// Purpose: valid/ready character stream bundle.
// Signals: in_valid (sender -> ctrl), in_data[7:0] (sender -> ctrl),
//          in_ready (ctrl -> sender).
// Modports: master = character sender, slave = string_seq_ctrl.

interface string_seq_ctrl_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/char_fifo.sv
// rtl/char_fifo.sv - small character FIFO between the stream input and the sequencer
//
// Purpose: DEPTH x 8 FIFO with show-ahead head output.
// Ports:   clk, clr (async active-high reset), push/wdata, pop/rdata (head),
//          full, empty.

module char_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [7:0]  mem [DEPTH];
    // One extra pointer bit distinguishes full from empty when the indexes match.
    logic [AW:0] wptr, rptr;

    logic do_push, do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (do_pop)  rptr <= rptr + PTR_ONE;
        end
    end

endmodule

// File: rtl/string_seq_ctrl.sv
// rtl/string_seq_ctrl.sv - front-end sequencer for the ASCII string recognizer
//
// Purpose: buffers incoming characters, splits them into strings at TERM,
//          clears the recognizer before each string, feeds it one character
//          per cycle and reports match/length per string.
// Ports:   clk, clr (async active-high reset)
//          in_if     : slave character stream (in_valid, in_data, in_ready)
//          rec_char, rec_en, rec_clr : drive the recognizer
//          rec_out   : recognizer result, valid the cycle after a sample
//          res_valid, res_match, res_len : per-string result
//          busy      : low only while waiting for input in FEED

module string_seq_ctrl
    import alu_pkg::*;
#(
    parameter int         DEPTH = 4,
    parameter int         LEN_W = 4,
    parameter logic [7:0] TERM  = CH_EQ
) (
    input  logic                 clk,
    input  logic                 clr,
    string_seq_ctrl_if.slave     in_if,
    output logic [7:0]           rec_char,
    output logic                 rec_en,
    output logic                 rec_clr,
    input  logic                 rec_out,
    output logic                 res_valid,
    output logic                 res_match,
    output logic [LEN_W-1:0]     res_len,
    output logic                 busy
);

    localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};
    localparam logic [LEN_W-1:0] LEN_ONE = 1;

    state_t           state;
    logic [LEN_W-1:0] len;
    logic [7:0]       head;
    logic             full, empty, pop;

    assign in_if.in_ready = ~full;
    assign pop            = (state == ST_FEED) & ~empty;

    // Combinational so the recognizer is also held clear while clr is high.
    assign rec_clr = clr | (state == ST_CLEAR);
    assign busy    = ~((state == ST_FEED) & empty);

    char_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .clr   (clr),
        .push  (in_if.in_valid),
        .wdata (in_if.in_data),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= ST_CLEAR;
            len       <= '0;
            rec_char  <= '0;
            rec_en    <= 1'b0;
            res_valid <= 1'b0;
            res_match <= 1'b0;
            res_len   <= '0;
        end else begin
            rec_en    <= 1'b0;
            res_valid <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    len   <= '0;
                    state <= ST_FEED;
                end
                ST_FEED: begin
                    if (!empty) begin
                        if (head == TERM) begin
                            state <= ST_SAMPLE;
                        end else begin
                            rec_char <= head;
                            rec_en   <= 1'b1;
                            if (len != LEN_MAX) len <= len + LEN_ONE;
                        end
                    end
                end
                ST_SAMPLE: begin
                    // rec_out now reflects the last forwarded character.
                    res_match <= (len != '0) & rec_out;
                    res_len   <= len;
                    res_valid <= 1'b1;
                    state     <= ST_REPORT;
                end
                ST_REPORT: begin
                    state <= ST_CLEAR;
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_string_seq_ctrl.sv
// tb/tb_string_seq_ctrl.sv - randomized self-checking bench for string_seq_ctrl

module tb_string_seq_ctrl;

    localparam logic [7:0] TERM_C = 8'd61;

    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] rec_char;
    logic       rec_en, rec_clr, rec_out;
    logic       res_valid, res_match, busy;
    logic [3:0] res_len;

    string_seq_ctrl_if sif ();

    string_seq_ctrl #(.DEPTH(4), .LEN_W(4), .TERM(8'd61)) dut (
        .clk       (clk),
        .clr       (clr),
        .in_if     (sif.slave),
        .rec_char  (rec_char),
        .rec_en    (rec_en),
        .rec_clr   (rec_clr),
        .rec_out   (rec_out),
        .res_valid (res_valid),
        .res_match (res_match),
        .res_len   (res_len),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Recognizer stand-in: single digit, then (op digit)*, other chars ignored.
    int rst_st;
    always @(posedge clk or posedge clr) begin
        if (clr) rst_st <= 0;
        else if (rec_clr) rst_st <= 0;
        else if (rec_en) begin
            if (rec_char >= 8'd48 && rec_char <= 8'd57)
                rst_st <= (rst_st == 0 || rst_st == 2) ? 1 : 3;
            else if (rec_char == 8'd42 || rec_char == 8'd43)
                rst_st <= (rst_st == 1) ? 2 : 3;
        end
    end
    assign rec_out = (rst_st == 1);

    // Reference model: strings as queues, results as plain arithmetic.
    logic [7:0] curr[$];
    logic [7:0] exp_chars[$];
    logic       exp_m[$];
    logic [3:0] exp_l[$];

    function automatic bit is_dig(input logic [7:0] c);
        return c >= 8'd48 && c <= 8'd57;
    endfunction

    function automatic bit is_op(input logic [7:0] c);
        return c == 8'd42 || c == 8'd43;
    endfunction

    function automatic bit accepts();
        logic [7:0] f[$];
        foreach (curr[i]) if (is_dig(curr[i]) || is_op(curr[i])) f.push_back(curr[i]);
        if (f.size() % 2 == 0) return 1'b0;
        foreach (f[i]) begin
            if ((i % 2) == 0 && !is_dig(f[i])) return 1'b0;
            if ((i % 2) == 1 && !is_op(f[i])) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_char(input logic [7:0] c);
        if (c == TERM_C) begin
            exp_m.push_back(accepts());
            exp_l.push_back(curr.size() > 15 ? 4'd15 : 4'(curr.size()));
            curr.delete();
        end else begin
            curr.push_back(c);
            exp_chars.push_back(c);
        end
    endtask

    // Output monitor.
    int         clr_cnt = 0, res_cnt = 0, stalls = 0;
    logic       last_m = 1'b0;
    logic [3:0] last_l = 4'd0;
    logic [7:0] mc;

    always @(negedge clk) begin
        if (!clr) begin
            if (rec_clr) clr_cnt++;
            if (rec_en) begin
                if (exp_chars.size() == 0) chk("rec_en_unexpected", 1, 0);
                else begin
                    mc = exp_chars.pop_front();
                    chk("rec_char", rec_char, mc);
                end
            end
            if (res_valid) begin
                res_cnt++;
                if (exp_m.size() == 0) chk("res_unexpected", 1, 0);
                else begin
                    last_m = exp_m.pop_front();
                    last_l = exp_l.pop_front();
                end
            end
            chk("res_match", res_match, last_m);
            chk("res_len", res_len, last_l);
        end
    end

    task automatic push(input logic [7:0] c);
        int n;
        @(negedge clk);
        sif.in_valid = 1'b1;
        sif.in_data  = c;
        n = 0;
        while (!sif.in_ready && n < 100) begin
            stalls++;
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            chk("push_timeout", 1, 0);
            sif.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            sif.in_valid = 1'b0;
            model_char(c);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((exp_m.size() != 0 || exp_chars.size() != 0 || busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drain"}, n < 500, 1);
        chk({tag, "_rec_clr_pulses"}, clr_cnt, res_cnt + 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        clr = 1'b1;
        curr.delete();
        exp_chars.delete();
        exp_m.delete();
        exp_l.delete();
        clr_cnt = 0;
        res_cnt = 0;
        last_m  = 1'b0;
        last_l  = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst_rec_en", rec_en, 0);
        chk("rst_rec_char", rec_char, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_match", res_match, 0);
        chk("rst_res_len", res_len, 0);
        chk("rst_rec_clr", rec_clr, 1);
        chk("rst_in_ready", sif.in_ready, 1);
        chk("rst_busy", busy, 1);
        @(posedge clk);
        #2;
        clr = 1'b0;
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) push(8'(s[i]));
    endtask

    function automatic logic [7:0] rand_char();
        int k = $urandom_range(0, 9);
        logic [7:0] c;
        if (k <= 4) return 8'd48 + 8'($urandom_range(0, 9));
        if (k == 5) return 8'd43;
        if (k == 6) return 8'd42;
        do c = 8'($urandom_range(32, 126)); while (c == TERM_C);
        return c;
    endfunction

    initial begin
        int stall_before;
        clr          = 1'b1;
        sif.in_valid = 1'b0;
        sif.in_data  = 8'd0;

        do_reset();

        push_str("5=");
        wait_idle("s1");
        push_str("57=");
        push_str("+5=");
        wait_idle("s2");
        push_str("5+5=");
        wait_idle("s3");
        push_str("=");
        wait_idle("s4");

        // FIFO fills while the sequencer is in SAMPLE/REPORT/CLEAR.
        stall_before = stalls;
        push_str("=5+5*5+=");
        wait_idle("s5");
        chk("stall_seen", stalls > stall_before, 1);

        // Abort mid-string.
        push(8'd53);
        repeat (4) @(negedge clk);
        do_reset();
        push_str("5=");
        wait_idle("s6");
        chk("abort_result_count", res_cnt, 1);

        // Randomized strings, including saturating lengths and gaps.
        for (int s = 0; s < 40; s++) begin
            int n = ($urandom_range(0, 5) == 0) ? $urandom_range(15, 22) : $urandom_range(0, 6);
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                push(rand_char());
            end
            push(TERM_C);
        end
        wait_idle("rand");

        chk("end_chars_empty", exp_chars.size(), 0);
        chk("end_res_empty", exp_m.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
